// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: default depth and Gray/binary conversions used by
// both the write-side and read-side pointer blocks.
package fifo_pkg;

    localparam int unsigned FIFO_DEFAULT_DEPTH = 8;
    localparam int unsigned FIFO_CONV_WIDTH    = 32;

    // Binary to Gray: each bit XORed with its upper neighbour.
    function automatic logic [FIFO_CONV_WIDTH-1:0] bin2gray(input logic [FIFO_CONV_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Gray to binary: running XOR from the MSB down; zero-extended inputs convert correctly.
    function automatic logic [FIFO_CONV_WIDTH-1:0] gray2bin(input logic [FIFO_CONV_WIDTH-1:0] gray);
        logic [FIFO_CONV_WIDTH-1:0] bin;
        bin = '0;
        bin[FIFO_CONV_WIDTH-1] = gray[FIFO_CONV_WIDTH-1];
        for (int i = FIFO_CONV_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into this clock domain.
// sync_nxt_o is the value the last flop will load on the next edge.
module gray_sync #(
    parameter int unsigned WIDTH       = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] sync_nxt_o
);

    logic [WIDTH-1:0] stage_q [SYNC_STAGES];

    // Shift chain with synchronous active-low clear of every stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= gray_i;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign sync_o     = stage_q[SYNC_STAGES-1];
    assign sync_nxt_o = stage_q[SYNC_STAGES-2];

endmodule

// File: rtl/write_ptr_ctrl.sv
// Write-side pointer control for an async FIFO: binary/Gray write pointer,
// read-pointer synchroniser, storage write strobe and overflow pulse.
// Optional feature: define WRITE_PTR_ALMOST_FULL_EN to add a registered almost_full output.
module write_ptr_ctrl
    import fifo_pkg::*;
#(
    parameter int unsigned depth       = FIFO_DEFAULT_DEPTH,
    parameter int unsigned adr_width   = $clog2(depth),
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AF_MARGIN   = 1
) (
    input  logic                 write_clk,
    input  logic                 write_rst_n,
    input  logic                 write_en,
    input  logic                 FIFO_full,
    input  logic [adr_width:0]   read_adr_gray,
    output logic [adr_width:0]   write_adr,
    output logic [adr_width:0]   write_adr_gray,
    output logic [adr_width:0]   read_adr,
    output logic                 mem_we,
    output logic [adr_width-1:0] mem_waddr,
    output logic                 overflow
`ifdef WRITE_PTR_ALMOST_FULL_EN
    ,
    output logic                 almost_full
`endif
);

    localparam int unsigned PW = adr_width + 1;

    logic          accept_c;
    logic [PW-1:0] write_adr_q;
    logic [PW-1:0] write_adr_d;
    logic [PW-1:0] write_adr_gray_q;
    logic          overflow_q;
    logic [PW-1:0] rd_gray_sync;
    logic [PW-1:0] rd_gray_nxt;

    // Accept term and next write pointer; no write is accepted while in reset.
    always_comb begin
        accept_c    = write_en && !FIFO_full && write_rst_n;
        write_adr_d = write_adr_q;
        if (accept_c) begin
            write_adr_d = write_adr_q + PW'(1);
        end
    end

    // Pointer registers; Gray form is registered from the next binary value.
    always_ff @(posedge write_clk) begin
        if (!write_rst_n) begin
            write_adr_q      <= '0;
            write_adr_gray_q <= '0;
            overflow_q       <= 1'b0;
        end else begin
            write_adr_q      <= write_adr_d;
            write_adr_gray_q <= PW'(bin2gray(FIFO_CONV_WIDTH'(write_adr_d)));
            overflow_q       <= write_en && FIFO_full;
        end
    end

    gray_sync #(
        .WIDTH       (PW),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_rd_sync (
        .clk        (write_clk),
        .rst_n      (write_rst_n),
        .gray_i     (read_adr_gray),
        .sync_o     (rd_gray_sync),
        .sync_nxt_o (rd_gray_nxt)
    );

    assign write_adr      = write_adr_q;
    assign write_adr_gray = write_adr_gray_q;
    assign read_adr       = PW'(gray2bin(FIFO_CONV_WIDTH'(rd_gray_sync)));
    assign mem_we         = accept_c;
    assign mem_waddr      = write_adr_q[adr_width-1:0];
    assign overflow       = overflow_q;

`ifdef WRITE_PTR_ALMOST_FULL_EN
    logic [PW-1:0] fill_nxt_c;
    logic          almost_full_q;

    // Occupancy from next-state write and read pointers.
    always_comb begin
        fill_nxt_c = write_adr_d - PW'(gray2bin(FIFO_CONV_WIDTH'(rd_gray_nxt)));
    end

    // Registered almost-full flag.
    always_ff @(posedge write_clk) begin
        if (!write_rst_n) begin
            almost_full_q <= 1'b0;
        end else begin
            almost_full_q <= (FIFO_CONV_WIDTH'(fill_nxt_c) >= FIFO_CONV_WIDTH'(depth - AF_MARGIN));
        end
    end

    assign almost_full = almost_full_q;
`else
    logic unused_rd_gray_nxt;
    assign unused_rd_gray_nxt = ^rd_gray_nxt;
`endif

endmodule

// File: tb/tb_write_ptr_ctrl.sv
// Directed bench for write_ptr_ctrl at depth 8 (4-bit pointers).
module tb_write_ptr_ctrl;

    logic       write_clk;
    logic       write_rst_n;
    logic       write_en;
    logic       FIFO_full;
    logic [3:0] read_adr_gray;
    logic [3:0] write_adr;
    logic [3:0] write_adr_gray;
    logic [3:0] read_adr;
    logic       mem_we;
    logic [2:0] mem_waddr;
    logic       overflow;
`ifdef WRITE_PTR_ALMOST_FULL_EN
    logic       almost_full;
`endif

    int total;
    int bad;

    write_ptr_ctrl dut (
        .write_clk      (write_clk),
        .write_rst_n    (write_rst_n),
        .write_en       (write_en),
        .FIFO_full      (FIFO_full),
        .read_adr_gray  (read_adr_gray),
        .write_adr      (write_adr),
        .write_adr_gray (write_adr_gray),
        .read_adr       (read_adr),
        .mem_we         (mem_we),
        .mem_waddr      (mem_waddr),
        .overflow       (overflow)
`ifdef WRITE_PTR_ALMOST_FULL_EN
        ,
        .almost_full    (almost_full)
`endif
    );

    // Full comparator of the surrounding FIFO: wrap bits differ, addresses equal.
    assign FIFO_full = (write_adr[3] != read_adr[3]) && (write_adr[2:0] == read_adr[2:0]);

    initial write_clk = 1'b0;
    always #5 write_clk = ~write_clk;

    function automatic logic [3:0] g4(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic test_reset();
        write_rst_n   = 1'b0;
        write_en      = 1'b1;
        read_adr_gray = 4'd0;
        repeat (3) @(posedge write_clk);
        @(negedge write_clk); #1;
        total++; if (write_adr !== 4'd0) begin bad++; $display("FAIL reset_wadr: got %0h want 0", write_adr); end
        total++; if (write_adr_gray !== 4'd0) begin bad++; $display("FAIL reset_wgray: got %0h want 0", write_adr_gray); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL reset_mem_we: got %0b want 0", mem_we); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL reset_overflow: got %0b want 0", overflow); end
        total++; if (read_adr !== 4'd0) begin bad++; $display("FAIL reset_radr: got %0h want 0", read_adr); end
        write_en    = 1'b0;
        write_rst_n = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            @(negedge write_clk);
            write_en = 1'b1;
            #1;
            total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL fill_mem_we[%0d]: got %0b want 1", i, mem_we); end
            total++; if (mem_waddr !== 3'(i)) begin bad++; $display("FAIL fill_waddr[%0d]: got %0d want %0d", i, mem_waddr, i); end
            total++; if (write_adr !== 4'(i)) begin bad++; $display("FAIL fill_wadr[%0d]: got %0d want %0d", i, write_adr, i); end
        end
        @(negedge write_clk);
        write_en = 1'b0;
        #1;
        total++; if (write_adr !== 4'b1000) begin bad++; $display("FAIL fill_wadr_end: got %b want 1000", write_adr); end
        total++; if (write_adr_gray !== 4'b1100) begin bad++; $display("FAIL fill_wgray_end: got %b want 1100", write_adr_gray); end
        total++; if (FIFO_full !== 1'b1) begin bad++; $display("FAIL fill_full: got %0b want 1", FIFO_full); end
    endtask

    task automatic test_overflow();
        @(negedge write_clk);
        write_en = 1'b1;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ovf_mem_we0: got %0b want 0", mem_we); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_pre: got %0b want 0", overflow); end
        @(negedge write_clk); #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL ovf_mem_we1: got %0b want 0", mem_we); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse1: got %0b want 1", overflow); end
        total++; if (write_adr !== 4'd8) begin bad++; $display("FAIL ovf_wadr1: got %0d want 8", write_adr); end
        @(negedge write_clk);
        write_en = 1'b0;
        #1;
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_pulse2: got %0b want 1", overflow); end
        total++; if (write_adr !== 4'd8) begin bad++; $display("FAIL ovf_wadr2: got %0d want 8", write_adr); end
        @(negedge write_clk); #1;
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clear: got %0b want 0", overflow); end
    endtask

    task automatic test_sync_latency();
        @(negedge write_clk);
        read_adr_gray = 4'b0001;
        #1;
        total++; if (read_adr !== 4'd0) begin bad++; $display("FAIL sync_lat0: got %0d want 0", read_adr); end
        @(negedge write_clk); #1;
        total++; if (read_adr !== 4'd0) begin bad++; $display("FAIL sync_lat1: got %0d want 0", read_adr); end
        @(negedge write_clk); #1;
        total++; if (read_adr !== 4'd1) begin bad++; $display("FAIL sync_lat2: got %0d want 1", read_adr); end
        total++; if (FIFO_full !== 1'b0) begin bad++; $display("FAIL sync_full_drop: got %0b want 0", FIFO_full); end
    endtask

    task automatic test_midstream_reset_and_wrap();
        logic [3:0] wp;
        logic [3:0] prev_gray;
        // Reset lands while a write is being requested.
        @(negedge write_clk);
        write_en    = 1'b1;
        write_rst_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL mid_rst_mem_we: got %0b want 0", mem_we); end
        @(negedge write_clk);
        read_adr_gray = 4'd0;
        #1;
        total++; if (write_adr !== 4'd0) begin bad++; $display("FAIL mid_rst_wadr: got %0d want 0", write_adr); end
        write_rst_n = 1'b1;
        wp        = 4'd0;
        prev_gray = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (i > 0) @(negedge write_clk);
            read_adr_gray = g4(wp);
            #1;
            total++; if (mem_we !== 1'b1) begin bad++; $display("FAIL wrap_mem_we[%0d]: got %0b want 1", i, mem_we); end
            total++; if (write_adr !== wp) begin bad++; $display("FAIL wrap_wadr[%0d]: got %0d want %0d", i, write_adr, wp); end
            total++; if (write_adr_gray !== g4(wp)) begin bad++; $display("FAIL wrap_wgray[%0d]: got %b want %b", i, write_adr_gray, g4(wp)); end
            if (i > 0) begin
                total++; if ($countones(write_adr_gray ^ prev_gray) != 1) begin bad++; $display("FAIL wrap_gray_step[%0d]: got %b from %b want one-bit change", i, write_adr_gray, prev_gray); end
            end
            prev_gray = write_adr_gray;
            wp = wp + 4'd1;
        end
        @(negedge write_clk);
        write_en = 1'b0;
        #1;
        total++; if (write_adr !== 4'd0) begin bad++; $display("FAIL wrap_wadr_end: got %0d want 0", write_adr); end
        total++; if (write_adr_gray !== 4'd0) begin bad++; $display("FAIL wrap_wgray_end: got %b want 0000", write_adr_gray); end
        total++; if ($countones(write_adr_gray ^ prev_gray) != 1) begin bad++; $display("FAIL wrap_gray_step_end: got %b from %b want one-bit change", write_adr_gray, prev_gray); end
    endtask

`ifdef WRITE_PTR_ALMOST_FULL_EN
    task automatic test_almost_full();
        @(negedge write_clk);
        write_rst_n   = 1'b0;
        write_en      = 1'b0;
        read_adr_gray = 4'd0;
        @(negedge write_clk);
        write_rst_n = 1'b1;
        #1;
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL af_reset: got %0b want 0", almost_full); end
        for (int i = 0; i < 7; i++) begin
            @(negedge write_clk);
            write_en = 1'b1;
        end
        @(negedge write_clk);
        write_en = 1'b0;
        #1;
        total++; if (write_adr !== 4'd7) begin bad++; $display("FAIL af_wadr: got %0d want 7", write_adr); end
        total++; if (almost_full !== 1'b1) begin bad++; $display("FAIL af_set: got %0b want 1", almost_full); end
        read_adr_gray = g4(4'd1);
        @(negedge write_clk); @(negedge write_clk); #1;
        total++; if (almost_full !== 1'b0) begin bad++; $display("FAIL af_clear: got %0b want 0", almost_full); end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_fill();
        test_overflow();
        test_sync_latency();
        test_midstream_reset_and_wrap();
`ifdef WRITE_PTR_ALMOST_FULL_EN
        test_almost_full();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
